// File: rtl/wb_timer.sv
// Wishbone-slave timer: prescaled 32-bit up-counter with a compare register,
// sticky match flag, optional auto-reload and a level interrupt.
module wb_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic [31:0] adr_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        int_o
);
    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_COMPARE  = 3'd2;
    localparam logic [2:0] ADDR_COUNT    = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    logic [2:0]            ctrl_r;
    logic [PRESCALE_W-1:0] prescale_r;
    logic [PRESCALE_W-1:0] pcnt_r;
    logic [31:0]           compare_r;
    logic [31:0]           count_r;
    logic                  match_r;
    logic                  ack_r;
    logic [31:0]           dat_r;

    logic                  req_s;
    logic                  wr_s;
    logic [2:0]            addr_s;
    logic                  tick_s;
    logic                  hit_s;
    logic                  status_clr_s;
    logic [31:0]           rdata_s;
    logic [2:0]            ctrl_wd_s;
    logic [PRESCALE_W-1:0] prescale_wd_s;
    logic                  unused_s;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // A new request is refused while the previous ack is still on the bus
    assign req_s         = cyc_i & stb_i & ~ack_r;
    assign wr_s          = req_s & we_i;
    assign addr_s        = adr_i[4:2];
    assign tick_s        = ctrl_r[0] & (pcnt_r == prescale_r);
    assign hit_s         = tick_s & (count_r == compare_r);
    assign status_clr_s  = wr_s & (addr_s == ADDR_STATUS) & sel_i[0] & dat_i[0];
    assign ctrl_wd_s     = 3'(lane_merge({29'd0, ctrl_r}, dat_i, sel_i));
    assign prescale_wd_s = PRESCALE_W'(lane_merge(32'(prescale_r), dat_i, sel_i));
    assign unused_s      = ^{adr_i[31:5], adr_i[1:0]};

    assign dat_o = dat_r;
    assign ack_o = ack_r;
    assign int_o = match_r & ctrl_r[2];

    // Read multiplexer over the register map
    always_comb begin
        rdata_s = 32'd0;
        case (addr_s)
            ADDR_CTRL:     rdata_s = {29'd0, ctrl_r};
            ADDR_PRESCALE: rdata_s = 32'(prescale_r);
            ADDR_COMPARE:  rdata_s = compare_r;
            ADDR_COUNT:    rdata_s = count_r;
            ADDR_STATUS:   rdata_s = {31'd0, match_r};
            default:       rdata_s = 32'd0;
        endcase
    end

    // Bus handshake: single-cycle ack, read data driven only alongside ack
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= req_s;
            if (req_s && !we_i) begin
                dat_r <= rdata_s;
            end else begin
                dat_r <= 32'd0;
            end
        end
    end

    // Configuration registers written from the bus
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_r     <= 3'd0;
            prescale_r <= {PRESCALE_W{1'b0}};
            compare_r  <= 32'd0;
        end else if (wr_s) begin
            case (addr_s)
                ADDR_CTRL:     ctrl_r     <= ctrl_wd_s;
                ADDR_PRESCALE: prescale_r <= prescale_wd_s;
                ADDR_COMPARE:  compare_r  <= lane_merge(compare_r, dat_i, sel_i);
                default:       ctrl_r     <= ctrl_r;
            endcase
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // Prescaler, counter and sticky match; bus writes to COUNT beat a tick
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_r  <= {PRESCALE_W{1'b0}};
            count_r <= 32'd0;
            match_r <= 1'b0;
        end else begin
            if (wr_s && ((addr_s == ADDR_CTRL) || (addr_s == ADDR_PRESCALE))) begin
                pcnt_r <= {PRESCALE_W{1'b0}};
            end else if (!ctrl_r[0] || tick_s) begin
                pcnt_r <= {PRESCALE_W{1'b0}};
            end else begin
                pcnt_r <= pcnt_r + PRESCALE_W'(1);
            end

            if (wr_s && (addr_s == ADDR_COUNT)) begin
                count_r <= lane_merge(count_r, dat_i, sel_i);
            end else if (hit_s && ctrl_r[1]) begin
                count_r <= 32'd0;
            end else if (tick_s) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end

            if (hit_s) begin
                match_r <= 1'b1;
            end else if (status_clr_s) begin
                match_r <= 1'b0;
            end else begin
                match_r <= match_r;
            end
        end
    end
endmodule
